// File: rtl/branch_target_predictor.sv
// ---------------------------------------------------------------------------
// branch_target_predictor
//
// Direct-mapped branch target buffer with 2-bit saturating direction
// counters for the lc3b fetch stage. Each cycle the fetch PC is looked up
// combinationally and a predicted next-fetch address is produced. Resolved
// branches from WB train the table at the clock edge.
//
// Ports:
//   clk            pipeline clock, all state updates on the rising edge
//   reset          asynchronous active-high reset, clears all table state
//   fetch_pc       PC of the instruction being fetched
//   predict_addr   predicted next fetch address
//   predict_taken  prediction is "taken"
//   predict_hit    fetch_pc matches a valid entry
//   update_en      one resolved branch is presented this cycle
//   update_pc      PC of the resolved branch
//   update_target  resolved target address
//   update_taken   the resolved branch was taken
//   invalidate     synchronous clear of every valid bit
// ---------------------------------------------------------------------------
module branch_target_predictor #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fetch_pc,
  output logic [15:0] predict_addr,
  output logic        predict_taken,
  output logic        predict_hit,
  input  logic        update_en,
  input  logic [15:0] update_pc,
  input  logic [15:0] update_target,
  input  logic        update_taken,
  input  logic        invalidate
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS   = 16 - 1 - INDEX_BITS;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [15:0]           target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;

  // Bit 0 of a PC never selects anything since instructions are word aligned.
  logic unused_pc_bits;
  assign unused_pc_bits = fetch_pc[0] ^ update_pc[0];

  assign fetch_idx = fetch_pc[INDEX_BITS:1];
  assign fetch_tag = fetch_pc[15:INDEX_BITS+1];
  assign upd_idx   = update_pc[INDEX_BITS:1];
  assign upd_tag   = update_pc[15:INDEX_BITS+1];

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Lookup reads the registered table only, so a same-cycle update to the
  // same index is not visible until after the edge (no write-through).
  always_comb begin
    predict_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    predict_taken = predict_hit && ctr_q[fetch_idx][1];
    predict_addr  = predict_taken ? target_q[fetch_idx] : fetch_pc + 16'd2;
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Table training. Invalidate takes priority over any update in the same
  // cycle and leaves counters and targets untouched. A not-taken miss is
  // not worth an entry, so only taken misses allocate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 16'h0000;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (invalidate) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (update_en) begin
      if (upd_hit) begin
        if (update_taken) begin
          ctr_q[upd_idx]    <= ctr_inc(ctr_q[upd_idx]);
          target_q[upd_idx] <= update_target;
        end else begin
          ctr_q[upd_idx] <= ctr_dec(ctr_q[upd_idx]);
        end
      end else if (update_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= update_target;
        ctr_q[upd_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_target_predictor
//
// Self-checking bench for branch_target_predictor (ENTRIES=8). A directed
// vector table walks the training, saturation, aliasing, same-cycle and
// invalidate scenarios with hand-derived expectations, a hand-written
// sequence covers asynchronous reset mid-update, and a randomized phase is
// checked against a behavioural table model.
// ---------------------------------------------------------------------------
module tb_branch_target_predictor;

  localparam int ENTRIES = 8;

  logic        clk;
  logic        reset;
  logic [15:0] fetch_pc;
  logic [15:0] predict_addr;
  logic        predict_taken;
  logic        predict_hit;
  logic        update_en;
  logic [15:0] update_pc;
  logic [15:0] update_target;
  logic        update_taken;
  logic        invalidate;

  int total;
  int bad;

  typedef struct {
    logic [15:0] fetch;
    logic        en;
    logic [15:0] upc;
    logic [15:0] utgt;
    logic        utaken;
    logic        inv;
    logic        ehit;
    logic        etaken;
    logic [15:0] eaddr;
  } vec_t;

  vec_t vecs [24];

  // Behavioural model of the table, indexed by word address modulo ENTRIES.
  bit          m_valid  [ENTRIES];
  int          m_tag    [ENTRIES];
  logic [15:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];

  branch_target_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_pc      (fetch_pc),
    .predict_addr  (predict_addr),
    .predict_taken (predict_taken),
    .predict_hit   (predict_hit),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken),
    .invalidate    (invalidate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_index(input logic [15:0] pc);
    return (int'(pc) / 2) % ENTRIES;
  endfunction

  function automatic int m_tagof(input logic [15:0] pc);
    return int'(pc) / (2 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = 16'h0000;
      m_ctr[i]    = 1;
    end
  endtask

  task automatic model_lookup(input logic [15:0] pc, output logic hit,
                              output logic taken, output logic [15:0] addr);
    int i;
    i     = m_index(pc);
    hit   = m_valid[i] && (m_tag[i] == m_tagof(pc));
    taken = hit && (m_ctr[i] >= 2);
    addr  = taken ? m_target[i] : 16'((int'(pc) + 2) % 65536);
  endtask

  task automatic model_update(input vec_t v);
    int  i;
    bit  hit;
    i   = m_index(v.upc);
    hit = m_valid[i] && (m_tag[i] == m_tagof(v.upc));
    if (v.inv) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (v.en) begin
      if (hit && v.utaken) begin
        m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_target[i] = v.utgt;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end else if (v.utaken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = m_tagof(v.upc);
        m_target[i] = v.utgt;
        m_ctr[i]    = 2;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    fetch_pc      = v.fetch;
    update_en     = v.en;
    update_pc     = v.upc;
    update_target = v.utgt;
    update_taken  = v.utaken;
    invalidate    = v.inv;
  endtask

  task automatic checkOutput(input string name, input logic ehit,
                             input logic etaken, input logic [15:0] eaddr);
    total++;
    if (predict_hit !== ehit || predict_taken !== etaken || predict_addr !== eaddr) begin
      bad++;
      $display("[TB] FAIL %s: got hit=%b taken=%b addr=%h, want hit=%b taken=%b addr=%h",
               name, predict_hit, predict_taken, predict_addr, ehit, etaken, eaddr);
    end
  endtask

  // One clock cycle: drive just after the falling edge, check the lookup
  // before the rising edge, then let the model see the same update.
  task automatic step(input string name, input vec_t v);
    applyStimulus(v);
    #1;
    checkOutput(name, v.ehit, v.etaken, v.eaddr);
    @(posedge clk);
    model_update(v);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [15:0] f, input logic en,
                              input logic [15:0] upc, input logic [15:0] utgt,
                              input logic ut, input logic inv, input logic eh,
                              input logic et, input logic [15:0] ea);
    vec_t v;
    v.fetch = f;   v.en = en;   v.upc = upc; v.utgt = utgt; v.utaken = ut;
    v.inv = inv;   v.ehit = eh; v.etaken = et; v.eaddr = ea;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic eh, et;
    logic [15:0] ea;

    total = 0;
    bad   = 0;

    // Directed table; each expectation is the lookup before that row's edge.
    vecs[0]  = mk(16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h3002);
    vecs[1]  = mk(16'hFFFE, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);
    vecs[2]  = mk(16'h3000, 1, 16'h3000, 16'h3100, 1, 0, 0, 0, 16'h3002);
    vecs[3]  = mk(16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h3100);
    vecs[4]  = mk(16'h3000, 1, 16'h3000, 16'h0000, 0, 0, 1, 1, 16'h3100);
    vecs[5]  = mk(16'h3000, 1, 16'h3000, 16'h0000, 0, 0, 1, 0, 16'h3002);
    vecs[6]  = mk(16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h3002);
    vecs[7]  = mk(16'h3000, 1, 16'h3000, 16'h3100, 1, 0, 1, 0, 16'h3002);
    vecs[8]  = mk(16'h3000, 1, 16'h3000, 16'h3100, 1, 0, 1, 0, 16'h3002);
    vecs[9]  = mk(16'h3000, 1, 16'h3000, 16'h3100, 1, 0, 1, 1, 16'h3100);
    vecs[10] = mk(16'h3000, 1, 16'h3000, 16'h3100, 1, 0, 1, 1, 16'h3100);
    vecs[11] = mk(16'h3000, 1, 16'h3000, 16'h0000, 0, 0, 1, 1, 16'h3100);
    vecs[12] = mk(16'h3000, 1, 16'h3000, 16'h3180, 1, 0, 1, 1, 16'h3100);
    vecs[13] = mk(16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h3180);
    vecs[14] = mk(16'h3010, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h3012);
    vecs[15] = mk(16'h3010, 1, 16'h3010, 16'h3200, 1, 0, 0, 0, 16'h3012);
    vecs[16] = mk(16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h3002);
    vecs[17] = mk(16'h3010, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h3200);
    vecs[18] = mk(16'h3002, 1, 16'h3002, 16'h3400, 0, 0, 0, 0, 16'h3004);
    vecs[19] = mk(16'h3002, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h3004);
    vecs[20] = mk(16'h3010, 1, 16'h3002, 16'h3300, 1, 1, 1, 1, 16'h3200);
    vecs[21] = mk(16'h3010, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h3012);
    vecs[22] = mk(16'h3002, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h3004);
    vecs[23] = mk(16'h3004, 1, 16'h3004, 16'h3600, 1, 0, 0, 0, 16'h3006);

    reset = 1'b1;
    applyStimulus(mk(16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of a cycle carrying an update.
    applyStimulus(mk(16'h3004, 1, 16'h3004, 16'h3700, 1, 0, 0, 0, 16'h0000));
    #1;
    checkOutput("pre_reset_hit", 1'b1, 1'b1, 16'h3600);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_drop", 1'b0, 1'b0, 16'h3006);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    update_en = 1'b0;
    #1;
    checkOutput("post_reset_3004", 1'b0, 1'b0, 16'h3006);
    fetch_pc = 16'h3010;
    #1;
    checkOutput("post_reset_3010", 1'b0, 1'b0, 16'h3012);
    @(negedge clk);

    // Randomized traffic over a small PC pool so hits and aliasing are common.
    for (int n = 0; n < 400; n++) begin
      v.fetch  = ($urandom_range(0, 31) == 0) ? 16'hFFFE
                                              : 16'h3000 + 16'(2 * $urandom_range(0, 23));
      v.en     = 1'($urandom_range(0, 2) != 0);
      v.upc    = 16'h3000 + 16'(2 * $urandom_range(0, 23));
      v.utgt   = 16'($urandom) & 16'hFFFE;
      v.utaken = 1'($urandom_range(0, 1));
      v.inv    = ($urandom_range(0, 39) == 0);
      model_lookup(v.fetch, eh, et, ea);
      v.ehit   = eh;
      v.etaken = et;
      v.eaddr  = ea;
      step($sformatf("rand%0d", n), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting in the fetch stage of the lc3b pipeline. Each cycle it looks up the fetch PC and supplies the predicted next-fetch address. That prediction travels down the pipeline and is compared against the resolved outcome by the WB-stage misprediction detector. Resolved branch outcomes from WB are written back into the table to train it.

## Interface
- ENTRIES, 8, number of table entries; a power of 2, from 2 to 64. INDEX_BITS = log2(ENTRIES).
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all table state.
- fetch_pc  input  16 (lc3b_word)  PC of the instruction being fetched.
- predict_addr  output  16 (lc3b_word)  predicted next fetch address.
- predict_taken  output  1  prediction is "taken".
- predict_hit  output  1  fetch_pc matches a valid entry.
- update_en  input  1  one resolved branch is presented at WB this cycle.
- update_pc  input  16 (lc3b_word)  PC of the resolved branch.
- update_target  input  16 (lc3b_word)  resolved target address.
- update_taken  input  1  the branch was actually taken.
- invalidate  input  1  synchronous clear of all valid bits.

## Operation
- Entry fields: valid (1), tag (16-1-INDEX_BITS), target (16), ctr (2).
- Index is pc[INDEX_BITS:1]; bit 0 is ignored because instructions are word aligned.
- Tag is pc[15:INDEX_BITS+1].
- Lookup is combinational from fetch_pc:
  - predict_hit = valid & (tag match).
  - predict_taken = predict_hit & ctr[1].
  - predict_addr = target when predict_taken; otherwise fetch_pc + 2, modulo 2^16 (0xFFFE wraps to 0x0000).
- Update, applied at the clock edge when update_en=1:
  - Hit on update_pc, taken: ctr saturating increment (max 2'b11). target is overwritten with update_target.
  - Hit on update_pc, not taken: ctr saturating decrement (min 2'b00). target and valid are unchanged.
  - Miss, taken: allocate or replace the indexed entry with valid=1, new tag, target=update_target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change.
- invalidate=1 clears every valid bit at the edge. ctr and target are left as they are.
- invalidate and update_en in the same cycle: invalidate wins and no allocation occurs.
- Reset, asserted asynchronously: all valid=0, all ctr=2'b01, all target=0x0000. Reset is honoured mid-update with no partial write.

## Timing
- Lookup latency is 0 cycles. Outputs are purely combinational from fetch_pc and the current table contents.
- Update becomes visible 1 cycle later, at the first lookup after the clock edge.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. There is no write-through bypass.
- At most one update per cycle. There is no handshake; update_en is a single-cycle strobe qualified by the WB stage.
- Output values during or after reset: predict_hit=0, predict_taken=0, predict_addr=fetch_pc+2.
- There is no stall input. The table is not written on cycles where update_en=0.

## Test plan
- Reset, then fetch_pc=0x3000: predict_hit=0, predict_taken=0, predict_addr=0x3002. At fetch_pc=0xFFFE: predict_addr=0x0000.
- update_en with pc=0x3000, target=0x3100, taken=1. On the next cycle, fetch_pc=0x3000 gives hit=1, taken=1, predict_addr=0x3100 (ctr=10).
- Continuing from the previous scenario, two not-taken updates for 0x3000: ctr goes 10→01→00. Lookup gives hit=1, taken=0, predict_addr=0x3002. Three taken updates then give ctr 01, 10, 11; a fourth taken update holds ctr at 11.
- Aliasing with ENTRIES=8: 0x3000 is trained taken. fetch_pc=0x3010 (same index, different tag) gives hit=0. A taken update at 0x3010 with target 0x3200 replaces the entry; afterwards 0x3000 misses and 0x3010 predicts 0x3200.
- Same-cycle conflict: fetch_pc=0x3000 while the first taken update for 0x3000 is presented. The same-cycle lookup gives addr=0x3002; the following cycle gives 0x3100.
- Assert reset asynchronously mid-cycle while update_en=1. Outputs drop to miss immediately, and after reset deasserts no entry is valid. Separately, invalidate together with update_en: no entry allocated.
